// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: parametrised multi-digit BCD modulo-N up/down counter with load, clear and cascade carry
// Ports: clk, rst (sync, active-high), clr (sync digit-clear), en (step enable), up_dn (1=up),
//        load/load_val (validated parallel BCD load), bcd (count), co (combinational carry/borrow),
//        load_err (one-cycle rejected-load flag), bin_out (binary copy of bcd).
// Optional: define BCD_BIN_OUT_EN to build the registered bin_out; otherwise it is tied to 0.
module bcd_mod_counter #(
    parameter int DIGITS = 2,
    parameter int MODULO = 60,
    parameter int BW     = $clog2(MODULO)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  co,
    output logic                  load_err,
    output logic [BW-1:0]         bin_out
);
    localparam int W = 4 * DIGITS;

    function automatic logic digits_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) ok = ok & (v[4*i+:4] <= 4'd9);
        return ok;
    endfunction

    function automatic int to_bin(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r;
        int m;
        r = '0;
        m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i+:4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULO - 1);

    logic [W-1:0] bcd_q, bcd_d, inc, dec, stepped;
    logic         load_err_q, load_err_d;
    logic         c, b, term, state_ok, load_ok;
    logic [3:0]   dig;

    always_comb begin
        inc = '0;
        dec = '0;
        c = 1'b1;
        b = 1'b1;
        dig = '0;
        // ripple increment/decrement: a digit moves only while every lower digit wraps
        for (int i = 0; i < DIGITS; i++) begin
            dig = bcd_q[4*i+:4];
            inc[4*i+:4] = c ? (dig == 4'd9 ? 4'd0 : dig + 4'd1) : dig;
            dec[4*i+:4] = b ? (dig == 4'd0 ? 4'd9 : dig - 4'd1) : dig;
            c = c & (dig == 4'd9);
            b = b & (dig == 4'd0);
        end
        term = up_dn ? (bcd_q == MAX_BCD) : (bcd_q == '0);
        state_ok = digits_ok(bcd_q) && (to_bin(bcd_q) < MODULO);
        load_ok = digits_ok(load_val) && (to_bin(load_val) < MODULO);
        // a corrupted count recovers to zero on the next enabled step
        stepped = !state_ok ? '0 : term ? (up_dn ? '0 : MAX_BCD) : (up_dn ? inc : dec);
        bcd_d = clr ? '0 : load ? (load_ok ? load_val : bcd_q) : en ? stepped : bcd_q;
        load_err_d = ~clr & load & ~load_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd      = bcd_q;
    assign load_err = load_err_q;
    assign co       = en & ~rst & ~clr & ~load & term;

`ifdef BCD_BIN_OUT_EN
    logic [BW-1:0] bin_q, bin_d;

    // converted from the next-state value so bin_out lands on the same edge as bcd
    always_comb bin_d = BW'(to_bin(bcd_d));

    always_ff @(posedge clk) begin
        if (rst) bin_q <= '0;
        else     bin_q <= bin_d;
    end

    assign bin_out = bin_q;
`else
    assign bin_out = '0;
`endif
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: directed self-checking bench for bcd_mod_counter (mod-60, cascaded mod-24, 3-digit mod-1000)
module tb_bcd_mod_counter;
`ifdef BCD_BIN_OUT_EN
    localparam bit BIN_EN = 1'b1;
`else
    localparam bit BIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       rst, clr, en, up_dn, load;
    logic [7:0] load_val, bcd;
    logic       co, load_err;
    logic [5:0] bin_out;

    logic       h_clr, h_up, h_load;
    logic [7:0] h_load_val, h_bcd;
    logic       h_co, h_err;
    logic [4:0] h_bin;

    logic        k_clr, k_en, k_up, k_load;
    logic [11:0] k_load_val, k_bcd;
    logic        k_co, k_err;
    logic [9:0]  k_bin;

    bcd_mod_counter #(.DIGITS(2), .MODULO(60)) u_sec (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .bcd(bcd), .co(co), .load_err(load_err), .bin_out(bin_out));

    bcd_mod_counter #(.DIGITS(2), .MODULO(24)) u_hr (
        .clk(clk), .rst(rst), .clr(h_clr), .en(co), .up_dn(h_up), .load(h_load),
        .load_val(h_load_val), .bcd(h_bcd), .co(h_co), .load_err(h_err), .bin_out(h_bin));

    bcd_mod_counter #(.DIGITS(3), .MODULO(1000)) u_k (
        .clk(clk), .rst(rst), .clr(k_clr), .en(k_en), .up_dn(k_up), .load(k_load),
        .load_val(k_load_val), .bcd(k_bcd), .co(k_co), .load_err(k_err), .bin_out(k_bin));

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 8'h45;
        #1;
        n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL reset_co got %b want 0", co); end
        step();
        step();
        n_vec++; if (bcd !== 8'h00) begin n_err++; $display("FAIL reset_bcd got %h want 00", bcd); end
        n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", load_err); end
        n_vec++; if (bin_out !== 6'd0) begin n_err++; $display("FAIL reset_bin got %0d want 0", bin_out); end
        n_vec++; if (k_bcd !== 12'h000) begin n_err++; $display("FAIL reset_k_bcd got %h want 000", k_bcd); end
        rst = 1'b0; load = 1'b0; en = 1'b0;
        #1;
    endtask

    task automatic test_count_up();
        en = 1'b1; up_dn = 1'b1;
        #1;
        for (int i = 0; i < 60; i++) begin
            n_vec++; if (bcd !== bcd2(i)) begin n_err++; $display("FAIL up_bcd[%0d] got %h want %h", i, bcd, bcd2(i)); end
            n_vec++; if (co !== (i == 59)) begin n_err++; $display("FAIL up_co[%0d] got %b want %b", i, co, i == 59); end
            n_vec++; if (bin_out !== (BIN_EN ? 6'(i) : 6'd0)) begin n_err++; $display("FAIL up_bin[%0d] got %0d want %0d", i, bin_out, BIN_EN ? i : 0); end
            step();
        end
        n_vec++; if (bcd !== 8'h00) begin n_err++; $display("FAIL up_wrap got %h want 00", bcd); end
    endtask

    task automatic test_count_down();
        up_dn = 1'b0;
        #1;
        n_vec++; if (co !== 1'b1) begin n_err++; $display("FAIL dn_co_at_0 got %b want 1", co); end
        step();
        n_vec++; if (bcd !== 8'h59) begin n_err++; $display("FAIL dn_wrap got %h want 59", bcd); end
        n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL dn_co_at_59 got %b want 0", co); end
        step();
        n_vec++; if (bcd !== 8'h58) begin n_err++; $display("FAIL dn_58 got %h want 58", bcd); end
        step();
        n_vec++; if (bcd !== 8'h57) begin n_err++; $display("FAIL dn_57 got %h want 57", bcd); end
        en = 1'b0; load = 1'b1; load_val = 8'h50;
        step();
        n_vec++; if (bcd !== 8'h50) begin n_err++; $display("FAIL dn_load50 got %h want 50", bcd); end
        load = 1'b0; en = 1'b1;
        step();
        n_vec++; if (bcd !== 8'h49) begin n_err++; $display("FAIL dn_borrow got %h want 49", bcd); end
        n_vec++; if (bin_out !== (BIN_EN ? 6'd49 : 6'd0)) begin n_err++; $display("FAIL dn_bin got %0d want %0d", bin_out, BIN_EN ? 49 : 0); end
        en = 1'b0;
        #1;
    endtask

    task automatic test_load();
        load = 1'b1; load_val = 8'h3A;
        step();
        n_vec++; if (load_err !== 1'b1) begin n_err++; $display("FAIL ld_3A_err got %b want 1", load_err); end
        n_vec++; if (bcd !== 8'h49) begin n_err++; $display("FAIL ld_3A_hold got %h want 49", bcd); end
        load = 1'b0;
        step();
        n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL ld_err_oneshot got %b want 0", load_err); end
        load = 1'b1; load_val = 8'h60;
        step();
        n_vec++; if (load_err !== 1'b1) begin n_err++; $display("FAIL ld_60_err got %b want 1", load_err); end
        n_vec++; if (bcd !== 8'h49) begin n_err++; $display("FAIL ld_60_hold got %h want 49", bcd); end
        load_val = 8'h45;
        step();
        n_vec++; if (bcd !== 8'h45) begin n_err++; $display("FAIL ld_45 got %h want 45", bcd); end
        n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL ld_45_err got %b want 0", load_err); end
        n_vec++; if (bin_out !== (BIN_EN ? 6'd45 : 6'd0)) begin n_err++; $display("FAIL ld_45_bin got %0d want %0d", bin_out, BIN_EN ? 45 : 0); end
        load = 1'b0;
        #1;
    endtask

    task automatic test_priority();
        rst = 1'b1; load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 8'h33;
        #1;
        n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL pri_rst_co got %b want 0", co); end
        step();
        n_vec++; if (bcd !== 8'h00) begin n_err++; $display("FAIL pri_rst_bcd got %h want 00", bcd); end
        rst = 1'b0; en = 1'b0;
        step();
        n_vec++; if (bcd !== 8'h33) begin n_err++; $display("FAIL pri_load33 got %h want 33", bcd); end
        clr = 1'b1; load_val = 8'h12;
        step();
        n_vec++; if (bcd !== 8'h00) begin n_err++; $display("FAIL pri_clr_bcd got %h want 00", bcd); end
        n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL pri_clr_err got %b want 0", load_err); end
        clr = 1'b0; load_val = 8'h59;
        step();
        n_vec++; if (bcd !== 8'h59) begin n_err++; $display("FAIL pri_load59 got %h want 59", bcd); end
        load = 1'b0; en = 1'b1;
        #1;
        n_vec++; if (co !== 1'b1) begin n_err++; $display("FAIL pri_co_59 got %b want 1", co); end
        clr = 1'b1;
        #1;
        n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL pri_clr_co got %b want 0", co); end
        clr = 1'b0; load = 1'b1; load_val = 8'h10;
        #1;
        n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL pri_load_co got %b want 0", co); end
        step();
        n_vec++; if (bcd !== 8'h10) begin n_err++; $display("FAIL pri_load_wins got %h want 10", bcd); end
        load = 1'b0; en = 1'b0;
        #1;
    endtask

    task automatic test_cascade();
        int pulses;
        pulses = 0;
        rst = 1'b1; en = 1'b0;
        step();
        rst = 1'b0; en = 1'b1; up_dn = 1'b1;
        #1;
        for (int cyc = 0; cyc < 1440; cyc++) begin
            if (h_co === 1'b1) pulses++;
            if (cyc == 1439) begin
                n_vec++; if (h_bcd !== 8'h23) begin n_err++; $display("FAIL cas_hr23 got %h want 23", h_bcd); end
                n_vec++; if (h_co !== 1'b1) begin n_err++; $display("FAIL cas_hr_co got %b want 1", h_co); end
            end
            step();
        end
        n_vec++; if (h_bcd !== 8'h00) begin n_err++; $display("FAIL cas_hr_wrap got %h want 00", h_bcd); end
        n_vec++; if (bcd !== 8'h00) begin n_err++; $display("FAIL cas_sec_wrap got %h want 00", bcd); end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL cas_pulses got %0d want 1", pulses); end
        n_vec++; if (h_bin !== (BIN_EN ? 5'd0 : 5'd0)) begin n_err++; $display("FAIL cas_hr_bin got %0d want 0", h_bin); end
        en = 1'b0;
        #1;
    endtask

    task automatic test_three_digit();
        k_load = 1'b1; k_load_val = 12'h999;
        step();
        n_vec++; if (k_bcd !== 12'h999) begin n_err++; $display("FAIL k_load999 got %h want 999", k_bcd); end
        n_vec++; if (k_bin !== (BIN_EN ? 10'd999 : 10'd0)) begin n_err++; $display("FAIL k_bin999 got %0d want %0d", k_bin, BIN_EN ? 999 : 0); end
        k_load = 1'b0; k_en = 1'b1; k_up = 1'b1;
        #1;
        n_vec++; if (k_co !== 1'b1) begin n_err++; $display("FAIL k_co999 got %b want 1", k_co); end
        step();
        n_vec++; if (k_bcd !== 12'h000) begin n_err++; $display("FAIL k_wrap got %h want 000", k_bcd); end
        k_en = 1'b0; k_up = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (k_bcd !== 12'h000) begin n_err++; $display("FAIL k_hold[%0d] got %h want 000", i, k_bcd); end
            n_vec++; if (k_co !== 1'b0) begin n_err++; $display("FAIL k_hold_co[%0d] got %b want 0", i, k_co); end
            step();
        end
        k_en = 1'b1;
        step();
        n_vec++; if (k_bcd !== 12'h999) begin n_err++; $display("FAIL k_down_wrap got %h want 999", k_bcd); end
        k_up = 1'b1; k_load = 1'b1; k_load_val = 12'h129;
        step();
        k_load = 1'b0;
        step();
        n_vec++; if (k_bcd !== 12'h130) begin n_err++; $display("FAIL k_ripple got %h want 130", k_bcd); end
        k_en = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
        h_clr = 1'b0; h_up = 1'b1; h_load = 1'b0; h_load_val = 8'h00;
        k_clr = 1'b0; k_en = 1'b0; k_up = 1'b1; k_load = 1'b0; k_load_val = 12'h000;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_priority();
        test_cascade();
        test_three_digit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
